circle_scene_seq: RTL and testbench
===================================

// Module: circle_scene_seq
// PURPOSE
// Scene sequencer upstream of the circle drawer, and pixel mux in front of vga_adapter (160x120).
// On go it clears the whole framebuffer to black, then draws NUM_RINGS concentric rings.
// Each ring is drawn by running one start/done handshake with circle.
// It forwards circle's pixel stream to the adapter while a ring is being drawn.
// PARAMETERS
// SCREEN_W     160  framebuffer width; clear raster x range 0..SCREEN_W-1
// SCREEN_H     120  framebuffer height; clear raster y range 0..SCREEN_H-1
// NUM_RINGS    4    rings drawn per scene, 1..16
// RADIUS_STEP  8    radius increment between successive rings
// PORTS
// clk           in   1  system clock (CLOCK_50)
// rst           in   1  synchronous reset, active-high
// go            in   1  level; scene starts when sampled high in IDLE
// centre_x      in   9  ring centre x, sampled at go
// centre_y      in   8  ring centre y, sampled at go
// base_radius   in   8  ring-0 radius, sampled at go
// base_colour   in   3  ring-0 colour, sampled at go
// circ_start    out  1  to circle.start
// circ_centre_x out  9  to circle.centre_x
// circ_centre_y out  8  to circle.centre_y
// circ_radius   out  8  to circle.radius
// circ_colour   out  3  to circle.colour
// circ_done     in   1  from circle.done
// circ_x/circ_y in  8/7 from circle.vga_x / circle.vga_y
// circ_pcol     in   3  from circle.vga_colour
// circ_plot     in   1  from circle.vga_plot
// vga_x/vga_y   out 8/7 to vga_adapter x / y
// vga_colour    out  3  to vga_adapter colour
// vga_plot      out  1  to vga_adapter plot
// busy          out  1  high in CLEAR, RING_RUN, RING_GAP
// done          out  1  high in DONE
// BEHAVIOUR
// - Reset: state IDLE; counters 0; all outputs 0, including circ_start, vga_plot, busy and done.
//   Reset mid-scene aborts at once; the next cycle has circ_start=0 and vga_plot=0.
// - IDLE: go=1 -> latch the four scene inputs, clear x=0 and y=0, ring index i=0, go to CLEAR.
// - CLEAR: registered outputs vga_plot=1, vga_colour=0, vga_x=x, vga_y=y.
//   - The first pixel (0,0) appears the cycle after go is sampled.
//   - x increments each cycle; at SCREEN_W-1 it wraps to 0 and y increments.
//   - After pixel (SCREEN_W-1,SCREEN_H-1) go to RING_RUN.
//   - Exactly SCREEN_W*SCREEN_H plots (19200), one per cycle, no gaps or repeats.
// - RING_RUN: circ_start=1; circ_centre_x/circ_centre_y are the latched centre.
//   - circ_radius = min(base_radius + i*RADIUS_STEP, 255), computed 12-bit and then saturated.
//   - circ_colour = (base_colour + i) mod 8.
//   - vga_* = circ_* passthrough, combinational, 0 added latency.
//   - circ_done=1 -> go to RING_GAP.
// - RING_GAP: exactly one cycle with circ_start=0 and vga_plot=0; circle returns to idle.
//   - If i==NUM_RINGS-1, go to DONE.
//   - Else i++ and go to RING_RUN, where ring parameters are stable in the same cycle circ_start rises.
// - DONE: done=1, vga_plot=0; stays until go=0, then IDLE.
//   Holding go high never starts a second scene.
// - go changes while busy are ignored. Scene inputs changing mid-scene have no effect.
// - circ_done asserted outside RING_RUN is ignored.
// - circ_plot outside RING_RUN is masked: vga_plot=0.
// - base_radius=0 is legal and still runs the handshake.
// STRUCTURE
// - Package scene_pkg:
//   - state_t enum {IDLE, CLEAR, RING_RUN, RING_GAP, DONE}
//   - SCREEN_W / SCREEN_H defaults
//   - widths XW=8, YW=7, CW=3
// - Sub-module clear_raster: x/y counter with en, wrap and last_pixel flag.
//   The FSM, ring-parameter datapath and output mux stay in the top.
// TESTING
// - Bench uses a stub circle: done rises 5 cycles after start, stays high until start falls.
//   The stub emits 3 plots at its centre.
// - Reset: assert rst for 2 cycles mid-CLEAR.
//   -> Next cycle all outputs 0, state IDLE; no plot until a new go.
// - Clear: go with centre (80,60).
//   -> 19200 plots, colour 0, each (x,y) exactly once, last (159,119).
//   -> circ_start first rises the cycle after the last clear pixel.
// - Rings: base_radius=10, base_colour=3.
//   -> 4 start pulses with radius 10/18/26/34 and colour 3/4/5/6, each separated by a 1-cycle low.
//   -> done=1 after the 4th ring.
// - Saturation/wrap: base_radius=250, base_colour=6.
//   -> radius 250/255/255/255, colour 6/7/0/1.
// - go held high through DONE -> no restart; drop go, raise go again -> a new CLEAR begins.
// - Masking: stub pulses circ_plot during CLEAR and DONE -> adapter sees only sequencer pixels.

Source files
------------

// File: rtl/scene_pkg.sv
// scene_pkg: shared FSM state encoding, screen defaults and pixel field widths for circle_scene_seq
package scene_pkg;
    typedef enum logic [2:0] {IDLE, CLEAR, RING_RUN, RING_GAP, DONE} state_t;
    localparam int SCREEN_W_DEF = 160;
    localparam int SCREEN_H_DEF = 120;
    localparam int XW = 8;
    localparam int YW = 7;
    localparam int CW = 3;
endpackage

// File: rtl/clear_raster.sv
// clear_raster: x/y raster counter for the framebuffer clear
//   clk, rst   : clock, synchronous active-high reset
//   clr        : restart at pixel (0,0)
//   en         : advance one pixel, x fastest, wrapping to (0,0) after the last pixel
//   x, y       : current pixel
//   last_pixel : current pixel is (W-1,H-1)
module clear_raster import scene_pkg::*; #(
    parameter int W = SCREEN_W_DEF,
    parameter int H = SCREEN_H_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last_pixel
);
    logic last_x;
    assign last_x     = x == XW'(W - 1);
    assign last_pixel = last_x && y == YW'(H - 1);
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            x <= '0;
            y <= '0;
        end else if (en) begin
            x <= last_x ? '0 : x + 1'b1;
            y <= last_x ? (last_pixel ? '0 : y + 1'b1) : y;
        end
    end
endmodule

// File: rtl/circle_scene_seq.sv
// circle_scene_seq: clears the 160x120 framebuffer, then draws NUM_RINGS concentric rings via circle
//   clk, rst                         : clock, synchronous active-high reset
//   go                               : level start, sampled in IDLE
//   centre_x/y, base_radius/colour   : scene inputs, latched at go
//   circ_start, circ_centre_x/y,
//   circ_radius, circ_colour         : request to the circle drawer
//   circ_done, circ_x/y, circ_pcol,
//   circ_plot                        : handshake and pixel stream from the circle drawer
//   vga_x/y, vga_colour, vga_plot    : pixel stream to vga_adapter
//   busy, done                       : scene status
module circle_scene_seq import scene_pkg::*; #(
    parameter int SCREEN_W    = SCREEN_W_DEF,
    parameter int SCREEN_H    = SCREEN_H_DEF,
    parameter int NUM_RINGS   = 4,
    parameter int RADIUS_STEP = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          go,
    input  logic [8:0]    centre_x,
    input  logic [7:0]    centre_y,
    input  logic [7:0]    base_radius,
    input  logic [CW-1:0] base_colour,
    output logic          circ_start,
    output logic [8:0]    circ_centre_x,
    output logic [7:0]    circ_centre_y,
    output logic [7:0]    circ_radius,
    output logic [CW-1:0] circ_colour,
    input  logic          circ_done,
    input  logic [XW-1:0] circ_x,
    input  logic [YW-1:0] circ_y,
    input  logic [CW-1:0] circ_pcol,
    input  logic          circ_plot,
    output logic [XW-1:0] vga_x,
    output logic [YW-1:0] vga_y,
    output logic [CW-1:0] vga_colour,
    output logic          vga_plot,
    output logic          busy,
    output logic          done
);
    localparam int IW = 4;
    state_t        state;
    logic [IW-1:0] i;
    logic [7:0]    br;
    logic [CW-1:0] bc;
    logic [11:0]   r12;
    logic [XW-1:0] rx;
    logic [YW-1:0] ry;
    logic          last_pixel;
    clear_raster #(.W(SCREEN_W), .H(SCREEN_H)) u_raster (
        .clk        (clk),
        .rst        (rst),
        .clr        (state == IDLE && go),
        .en         (state == CLEAR),
        .x          (rx),
        .y          (ry),
        .last_pixel (last_pixel)
    );
    // Ring parameters follow the registered ring index, so they are already valid when circ_start rises.
    always_comb begin
        r12         = 12'(br) + 12'(i) * 12'(RADIUS_STEP);
        circ_radius = r12 > 12'd255 ? 8'hFF : r12[7:0];
        circ_colour = bc + CW'(i);
        vga_x       = state == RING_RUN ? circ_x : rx;
        vga_y       = state == RING_RUN ? circ_y : ry;
        vga_colour  = state == RING_RUN ? circ_pcol : '0;
        vga_plot    = state == CLEAR || (state == RING_RUN && circ_plot);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            i             <= '0;
            br            <= '0;
            bc            <= '0;
            circ_centre_x <= '0;
            circ_centre_y <= '0;
            circ_start    <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            case (state)
                IDLE: if (go) begin
                    state         <= CLEAR;
                    i             <= '0;
                    br            <= base_radius;
                    bc            <= base_colour;
                    circ_centre_x <= centre_x;
                    circ_centre_y <= centre_y;
                    busy          <= 1'b1;
                end
                CLEAR: if (last_pixel) begin
                    state      <= RING_RUN;
                    circ_start <= 1'b1;
                end
                RING_RUN: if (circ_done) begin
                    state      <= RING_GAP;
                    circ_start <= 1'b0;
                end
                RING_GAP: if (i == IW'(NUM_RINGS - 1)) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end else begin
                    state      <= RING_RUN;
                    i          <= i + 1'b1;
                    circ_start <= 1'b1;
                end
                DONE: if (!go) begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_circle_scene_seq.sv
// tb_circle_scene_seq: directed scenes against a stub circle drawer with a ring-parameter scoreboard
module tb_circle_scene_seq;
    logic       clk = 1'b0;
    logic       rst, go;
    logic [8:0] centre_x;
    logic [7:0] centre_y, base_radius;
    logic [2:0] base_colour;
    logic       circ_start, circ_done, circ_plot, vga_plot, busy, done;
    logic [8:0] circ_centre_x;
    logic [7:0] circ_centre_y, circ_radius, circ_x, vga_x;
    logic [2:0] circ_colour, circ_pcol, vga_colour;
    logic [6:0] circ_y, vga_y;

    circle_scene_seq dut (
        .clk(clk), .rst(rst), .go(go), .centre_x(centre_x), .centre_y(centre_y),
        .base_radius(base_radius), .base_colour(base_colour), .circ_start(circ_start),
        .circ_centre_x(circ_centre_x), .circ_centre_y(circ_centre_y), .circ_radius(circ_radius),
        .circ_colour(circ_colour), .circ_done(circ_done), .circ_x(circ_x), .circ_y(circ_y),
        .circ_pcol(circ_pcol), .circ_plot(circ_plot), .vga_x(vga_x), .vga_y(vga_y),
        .vga_colour(vga_colour), .vga_plot(vga_plot), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int scnt = 0;
    logic noise = 1'b0;
    logic nb;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) scnt <= circ_start ? scnt + 1 : 0;

    // Stub circle: done 5 cycles after start, 3 plots at the centre; junk pixels/done when noise is on.
    assign nb        = noise & cyc[0];
    assign circ_done = circ_start ? (scnt >= 5) : nb;
    assign circ_plot = circ_start ? (scnt < 3) : nb;
    assign circ_x    = circ_start ? circ_centre_x[7:0] : 8'd7;
    assign circ_y    = circ_start ? circ_centre_y[6:0] : 7'd5;
    assign circ_pcol = circ_start ? circ_colour : 3'd7;

    int checks = 0, passed = 0, fails = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    typedef struct {int r; int c;} ring_t;
    ring_t sb[$];
    ring_t e;

    logic       mon = 1'b0;
    logic [8:0] exp_cx = '0;
    logic [7:0] exp_cy = '0;
    int g_cyc = -100000;
    int k, fall_cyc = -1;
    int clr_ok = 0, clr_err = 0, last_ok = 0, pass_err = 0, ring_plots = 0;
    int stray = 0, starts = 0, gap_ok = 0, gap_err = 0;
    logic prev_start = 1'b0;

    always @(negedge clk) begin
        if (mon) begin
            if (cyc >= g_cyc && cyc < g_cyc + 19200) begin
                k = cyc - g_cyc;
                if (k == 0) last_ok = 0;
                if (vga_plot === 1'b1 && vga_x === 8'(k % 160) && vga_y === 7'(k / 160) && vga_colour === 3'd0)
                    clr_ok++;
                else
                    clr_err++;
                if (k == 19199) last_ok = (vga_x === 8'd159 && vga_y === 7'd119) ? 1 : 0;
            end else if (circ_start) begin
                if (vga_plot !== circ_plot || vga_x !== circ_x || vga_y !== circ_y || vga_colour !== circ_pcol)
                    pass_err++;
                if (vga_plot === 1'b1) ring_plots++;
            end else if (vga_plot !== 1'b0) begin
                stray++;
            end
            if (circ_start && !prev_start) begin
                starts++;
                if (fall_cyc > g_cyc) begin
                    if (cyc - fall_cyc == 1) gap_ok++; else gap_err++;
                end else begin
                    chk("first_start_cycle", cyc - g_cyc, 19200);
                end
                chk("sb_pending", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("ring_radius", int'(circ_radius), e.r);
                    chk("ring_colour", int'(circ_colour), e.c);
                end
                chk("ring_centre", int'({circ_centre_x, circ_centre_y}), int'({exp_cx, exp_cy}));
            end
            if (!circ_start && prev_start) fall_cyc = cyc;
        end
        prev_start = circ_start;
    end

    task automatic reset_check(input string tag);
        chk({tag, "_ctl"}, int'({circ_start, vga_plot, busy, done}), 0);
        chk({tag, "_data"}, int'({vga_x, vga_y, vga_colour, circ_radius, circ_colour}), 0);
        chk({tag, "_centre"}, int'({circ_centre_x, circ_centre_y}), 0);
    endtask

    // go_mode 0: go held high throughout; 1: go dropped early and glitched mid-clear.
    task automatic run_scene(input int cx, input int cy, input int br, input int bc, input int go_mode);
        int s_ok = clr_ok, s_err = clr_err, s_pe = pass_err, s_rp = ring_plots, s_st = stray;
        int s_starts = starts, s_gok = gap_ok, s_gerr = gap_err, n = 0;
        for (int j = 0; j < 4; j++) begin
            ring_t t;
            t.r = (br + 8 * j > 255) ? 255 : br + 8 * j;
            t.c = (bc + j) % 8;
            sb.push_back(t);
        end
        @(negedge clk);
        centre_x = 9'(cx); centre_y = 8'(cy); base_radius = 8'(br); base_colour = 3'(bc);
        exp_cx = 9'(cx); exp_cy = 8'(cy);
        go = 1'b1;
        g_cyc = cyc + 1;
        @(negedge clk);
        chk("busy_in_clear", int'(busy), 1);
        repeat (3) @(negedge clk);
        centre_x = 9'd3; centre_y = 8'd4; base_radius = 8'd99; base_colour = 3'd0;
        if (go_mode == 1) go = 1'b0;
        repeat (40) @(negedge clk);
        if (go_mode == 1) begin
            go = 1'b1;
            @(negedge clk);
            go = 1'b0;
        end
        while (done !== 1'b1 && n < 25000) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", int'(done), 1);
        chk("busy_at_done", int'(busy), 0);
        chk("clear_pixels", clr_ok - s_ok, 19200);
        chk("clear_bad", clr_err - s_err, 0);
        chk("clear_last", last_ok, 1);
        chk("ring_starts", starts - s_starts, 4);
        chk("ring_gaps", gap_ok - s_gok, 3);
        chk("ring_gap_bad", gap_err - s_gerr, 0);
        chk("ring_plots", ring_plots - s_rp, 12);
        chk("passthru_bad", pass_err - s_pe, 0);
        chk("stray_plots", stray - s_st, 0);
        chk("sb_empty", sb.size(), 0);
    endtask

    initial begin
        int n, s, s2;
        rst = 1'b1; go = 1'b0;
        centre_x = '0; centre_y = '0; base_radius = '0; base_colour = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_check("reset");
        rst = 1'b0;
        // abort a scene mid-clear
        centre_x = 9'd80; centre_y = 8'd60; base_radius = 8'd10; base_colour = 3'd3;
        go = 1'b1;
        repeat (100) @(negedge clk);
        chk("busy_mid_clear", int'(busy), 1);
        chk("plot_mid_clear", int'(vga_plot), 1);
        rst = 1'b1; go = 1'b0;
        @(negedge clk);
        reset_check("reset_mid");
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        repeat (30) begin
            @(negedge clk);
            if (vga_plot !== 1'b0 || busy !== 1'b0) n++;
        end
        chk("quiet_after_reset", n, 0);
        mon = 1'b1;
        // scene A with go held high, then held through DONE
        run_scene(80, 60, 10, 3, 0);
        s = starts; s2 = stray;
        repeat (30) @(negedge clk);
        chk("hold_done", int'(done), 1);
        chk("hold_no_restart", starts - s, 0);
        chk("hold_no_plot", stray - s2, 0);
        go = 1'b0;
        @(negedge clk);
        chk("done_drop", int'(done), 0);
        chk("idle_not_busy", int'(busy), 0);
        s2 = stray;
        noise = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle_mask", stray - s2, 0);
        // scene B: radius saturation, colour wrap, noisy circle outside ring draws
        run_scene(80, 60, 250, 6, 1);
        @(negedge clk);
        chk("done_one_cycle", int'(done), 0);
        repeat (10) @(negedge clk);
        noise = 1'b0;
        // scene C: zero base radius still runs all handshakes
        run_scene(20, 30, 0, 7, 1);
        @(negedge clk);
        chk("final_idle", int'({busy, done, vga_plot}), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
